// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions three raw buttons (sync, debounce, press detect)
// and sequences run/pause/lap/clear, producing the counter tick, clear and freeze.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_start_stop_i,
  input  logic       btn_lap_i,
  input  logic       btn_clear_i,
  output logic       count_tick_o,
  output logic       count_clear_o,
  output logic       display_freeze_o,
  output logic [1:0] state_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  logic [2:0] btnRaw;
  logic [2:0] pressEv;

  assign btnRaw = {btn_clear_i, btn_lap_i, btn_start_stop_i};

  // Bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          levelPrev_q;
    logic [CW-1:0] dbCnt_q;
    logic [CW-1:0] dbCnt_d;

    // The counter tallies consecutive samples that disagree with the accepted
    // level; any agreeing sample throws the partial count away.
    always_comb begin
      level_d = level_q;
      dbCnt_d = '0;
      if (sync2_q != level_q) begin
        if (dbCnt_q == DEB_LAST) begin
          level_d = sync2_q;
        end else begin
          dbCnt_d = dbCnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        level_q     <= 1'b0;
        levelPrev_q <= 1'b0;
        dbCnt_q     <= '0;
      end else begin
        sync1_q     <= btnRaw[b];
        sync2_q     <= sync1_q;
        level_q     <= level_d;
        levelPrev_q <= level_q;
        dbCnt_q     <= dbCnt_d;
      end
    end

    assign pressEv[b] = level_q & ~levelPrev_q;
  end

  logic          ssEv;
  logic          lapEv;
  logic          clrEv;
  logic          clrAct;
  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          clear_q;
  logic          freeze_q;

  assign ssEv   = pressEv[0];
  assign lapEv  = pressEv[1];
  assign clrEv  = pressEv[2];
  assign clrAct = clrEv && (state_q == IDLE || state_q == PAUSE);

  // Only the highest-priority event that is legal in the current state acts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!clrEv && ssEv) state_d = RUN;
      RUN:     if (ssEv) state_d = PAUSE;
               else if (lapEv) state_d = LAP;
      LAP:     if (ssEv) state_d = PAUSE;
               else if (lapEv) state_d = RUN;
      PAUSE:   if (clrEv) state_d = IDLE;
               else if (ssEv) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // The prescaler advances on the current state, so a wrap on the pausing edge
  // still ticks, and PAUSE keeps the partial period for the resume.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      clear_q  <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze_q <= (state_d == LAP);
      clear_q  <= clrAct;
      tick_q   <= 1'b0;
      if (clrAct || state_q == IDLE) begin
        presc_q <= '0;
      end else if (state_q == RUN || state_q == LAP) begin
        if (presc_q == PRESC_LAST) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign count_tick_o     = tick_q;
  assign count_clear_o    = clear_q;
  assign display_freeze_o = freeze_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-sample debounce; a press
// acts on the 7th edge after the button first reads high.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnStartStop;
  logic       btnLap;
  logic       btnClear;
  logic       countTick;
  logic       countClear;
  logic       displayFreeze;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int runStart   = 0;

  stopwatch_ctrl #(
    .CLK_HZ(1000),
    .TICK_HZ(100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .btn_start_stop_i(btnStartStop),
    .btn_lap_i(btnLap),
    .btn_clear_i(btnClear),
    .count_tick_o(countTick),
    .count_clear_o(countClear),
    .display_freeze_o(displayFreeze),
    .state_o(state)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Ticks land every 10 edges after the phase reference while counting.
  function automatic logic phaseTick(input int c);
    return (c > runStart) && (((c - runStart) % 10) == 0);
  endfunction

  task automatic test_reset;
    rst          = 1'b1;
    btnStartStop = 1'b0;
    btnLap       = 1'b0;
    btnClear     = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== 5'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold: got %b, expected 00000", {state, displayFreeze, countTick, countClear});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== 5'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_after_reset: got %b, expected 00000", {state, displayFreeze, countTick, countClear});
      end
    end
  endtask

  task automatic test_start;
    logic [1:0] es;
    logic       et;
    int         e0;
    e0 = cyc;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 12) btnStartStop = 1'b0;
      es = (k >= 7) ? S_RUN : S_IDLE;
      et = (k >= 17) && (((k - 7) % 10) == 0);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL start_run k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    runStart = e0 + 7;
  endtask

  task automatic test_bounce;
    logic et;
    btnLap = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k < 20 && (k % 2) == 0) btnLap = ~btnLap;
      if (k == 20) btnLap = 1'b0;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {S_RUN, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL bounce_lap k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {S_RUN, 1'b0, et, 1'b0});
      end
    end
  endtask

  task automatic test_pause_resume;
    logic [1:0] es;
    logic       et;
    int         e0;
    int         p;
    int         r;
    while (((cyc - runStart) % 10) != 8) @(negedge clk);
    e0 = cyc;
    p  = e0 + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_PAUSE : S_RUN;
      et = (cyc <= p) && phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL pause_entry k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {S_PAUSE, 3'b000}) begin
        mismatched++;
        $display("[TB] FAIL paused_hold k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {S_PAUSE, 3'b000});
      end
    end
    e0 = cyc;
    r  = e0 + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_RUN : S_PAUSE;
      et = (cyc == r + 5);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL resume_tick k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    runStart = r - 5;
  endtask

  task automatic test_lap;
    logic [1:0] es;
    logic       et;
    btnLap = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnLap = 1'b0;
      es = (k >= 7) ? S_LAP : S_RUN;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, es == S_LAP, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL lap_enter k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, es == S_LAP, et, 1'b0});
      end
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {S_LAP, 1'b1, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL lap_counting k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {S_LAP, 1'b1, et, 1'b0});
      end
    end
    btnLap = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnLap = 1'b0;
      es = (k >= 7) ? S_RUN : S_LAP;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, es == S_LAP, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL lap_exit k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, es == S_LAP, et, 1'b0});
      end
    end
  endtask

  task automatic test_clear;
    logic [1:0] es;
    logic       et;
    logic       ec;
    int         p;
    btnClear = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnClear = 1'b0;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {S_RUN, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL clear_in_run_ignored k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {S_RUN, 1'b0, et, 1'b0});
      end
    end
    p = cyc + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_PAUSE : S_RUN;
      et = (cyc <= p) && phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL pause_for_clear k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    btnClear = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnClear = 1'b0;
      es = (k >= 7) ? S_IDLE : S_PAUSE;
      ec = (k == 7);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, 1'b0, ec}) begin
        mismatched++;
        $display("[TB] FAIL clear_from_pause k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, 1'b0, ec});
      end
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== 5'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_after_clear k=%0d: got %b, expected 00000", k, {state, displayFreeze, countTick, countClear});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] es;
    logic       et;
    logic       ec;
    int         p;
    btnClear = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnClear = 1'b0;
      ec = (k == 7);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {S_IDLE, 1'b0, 1'b0, ec}) begin
        mismatched++;
        $display("[TB] FAIL clear_in_idle k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {S_IDLE, 1'b0, 1'b0, ec});
      end
    end
    runStart = cyc + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_RUN : S_IDLE;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL restart_run k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    p = cyc + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_PAUSE : S_RUN;
      et = (cyc <= p) && phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL repause k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    btnStartStop = 1'b1;
    btnClear     = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) begin
        btnStartStop = 1'b0;
        btnClear     = 1'b0;
      end
      es = (k >= 7) ? S_IDLE : S_PAUSE;
      ec = (k == 7);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, 1'b0, ec}) begin
        mismatched++;
        $display("[TB] FAIL simul_clear_wins k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, 1'b0, ec});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] es;
    logic       et;
    runStart = cyc + 7;
    btnStartStop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) btnStartStop = 1'b0;
      es = (k >= 7) ? S_RUN : S_IDLE;
      et = phaseTick(cyc);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== {es, 1'b0, et, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL run_before_reset k=%0d: got %b, expected %b", k, {state, displayFreeze, countTick, countClear}, {es, 1'b0, et, 1'b0});
      end
    end
    while (cyc < runStart + 10) @(negedge clk);
    compared++;
    if ({state, countTick} !== {S_RUN, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL tick_before_reset: got %b, expected %b", {state, countTick}, {S_RUN, 1'b1});
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({state, displayFreeze, countTick, countClear} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %b, expected 00000", {state, displayFreeze, countTick, countClear});
    end
    for (int k = 1; k <= 3; k++) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      compared++;
      if ({state, displayFreeze, countTick, countClear} !== 5'b0) begin
        mismatched++;
        $display("[TB] FAIL after_reset_release k=%0d: got %b, expected 00000", k, {state, displayFreeze, countTick, countClear});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_pause_resume();
    test_lap();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
